// File: rtl/cdnsdru_usb4_message_bus_link_eval_req_regs_v4_if.sv
// rtl/cdnsdru_usb4_message_bus_link_eval_req_regs_v4_if.sv - decoded MB register write bus
interface cdnsdru_usb4_message_bus_link_eval_req_regs_v4_if;
  logic        mb_rx_wr_valid;
  logic [11:0] mb_rx_wr_addr;
  logic [7:0]  mb_rx_wr_data;

  modport master (
    output mb_rx_wr_valid,
    output mb_rx_wr_addr,
    output mb_rx_wr_data
  );

  modport slave (
    input mb_rx_wr_valid,
    input mb_rx_wr_addr,
    input mb_rx_wr_data
  );
endinterface

// File: rtl/cdnsdru_usb4_message_bus_link_eval_req_regs_v4.sv
// rtl/cdnsdru_usb4_message_bus_link_eval_req_regs_v4.sv - RX Control3 link-eval request FSM
module cdnsdru_usb4_message_bus_link_eval_req_regs_v4 #(
  parameter logic [11:0] ADDR_RX_CTRL3 = 12'h003,
  parameter logic [15:0] TIMEOUT_CYC   = 16'd4096
) (
  input  logic                                          pipe_mac2phy_clk,
  input  logic                                          pipe_mac2phy_rstn,
  input  logic                                          cdb_reset,
  input  logic                                          cdb_ctrl_reset,
  cdnsdru_usb4_message_bus_link_eval_req_regs_v4_if.slave mb,
  input  logic                                          pma_eval_done,
  input  logic [3:0]                                    pipe_rate_mac2phy_sync,
  output logic                                          rx_eq_eval,
  output logic                                          rx_eq_eval_sel,
  output logic                                          pma_eval_req,
  output logic                                          pma_eval_g67,
  output logic                                          phy_status,
  output logic                                          eval_busy,
  output logic                                          eval_timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_PMA = 2'd1,
    STATUS   = 2'd2,
    HOLD     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rx_eq_eval_q, rx_eq_eval_d;
  logic        rx_eq_eval_sel_q, rx_eq_eval_sel_d;
  logic        pma_eval_req_q, pma_eval_req_d;
  logic        pma_eval_g67_q, pma_eval_g67_d;
  logic        eval_timeout_err_q, eval_timeout_err_d;

  logic ctrl3_wr, wr_start, wr_stop, timeout_hit;
  logic unused_wr_data;

  assign ctrl3_wr       = mb.mb_rx_wr_valid && (mb.mb_rx_wr_addr == ADDR_RX_CTRL3);
  assign wr_start       = ctrl3_wr && mb.mb_rx_wr_data[0];
  assign wr_stop        = ctrl3_wr && !mb.mb_rx_wr_data[0];
  assign timeout_hit    = (cnt_q == (TIMEOUT_CYC - 16'd1));
  assign unused_wr_data = ^mb.mb_rx_wr_data[7:2];

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    rx_eq_eval_d       = rx_eq_eval_q;
    rx_eq_eval_sel_d   = rx_eq_eval_sel_q;
    pma_eval_req_d     = pma_eval_req_q;
    pma_eval_g67_d     = pma_eval_g67_q;
    eval_timeout_err_d = eval_timeout_err_q;

    case (state_q)
      IDLE: begin
        if (wr_start) begin
          state_d            = WAIT_PMA;
          rx_eq_eval_d       = 1'b1;
          pma_eval_req_d     = 1'b1;
          rx_eq_eval_sel_d   = mb.mb_rx_wr_data[1];
          pma_eval_g67_d     = (pipe_rate_mac2phy_sync == 4'b0101);
          cnt_d              = 16'd0;
          eval_timeout_err_d = 1'b0;
        end else if (wr_stop) begin
          rx_eq_eval_d = 1'b0;
        end
      end
      WAIT_PMA: begin
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        // Abort outranks both done and timeout so no status pulse escapes.
        if (wr_stop) begin
          state_d        = IDLE;
          rx_eq_eval_d   = 1'b0;
          pma_eval_req_d = 1'b0;
        end else if (pma_eval_done) begin
          state_d        = STATUS;
          pma_eval_req_d = 1'b0;
        end else if (timeout_hit) begin
          state_d            = STATUS;
          pma_eval_req_d     = 1'b0;
          eval_timeout_err_d = 1'b1;
        end
      end
      STATUS: state_d = HOLD;
      HOLD: begin
        if (wr_stop) begin
          state_d      = IDLE;
          rx_eq_eval_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cdb_reset || cdb_ctrl_reset) begin
      state_d            = IDLE;
      cnt_d              = 16'd0;
      rx_eq_eval_d       = 1'b0;
      rx_eq_eval_sel_d   = 1'b0;
      pma_eval_req_d     = 1'b0;
      pma_eval_g67_d     = 1'b0;
      eval_timeout_err_d = 1'b0;
    end
  end

  always_ff @(posedge pipe_mac2phy_clk or negedge pipe_mac2phy_rstn) begin
    if (!pipe_mac2phy_rstn) begin
      state_q            <= IDLE;
      cnt_q              <= 16'd0;
      rx_eq_eval_q       <= 1'b0;
      rx_eq_eval_sel_q   <= 1'b0;
      pma_eval_req_q     <= 1'b0;
      pma_eval_g67_q     <= 1'b0;
      eval_timeout_err_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      rx_eq_eval_q       <= rx_eq_eval_d;
      rx_eq_eval_sel_q   <= rx_eq_eval_sel_d;
      pma_eval_req_q     <= pma_eval_req_d;
      pma_eval_g67_q     <= pma_eval_g67_d;
      eval_timeout_err_q <= eval_timeout_err_d;
    end
  end

  assign rx_eq_eval       = rx_eq_eval_q;
  assign rx_eq_eval_sel   = rx_eq_eval_sel_q;
  assign pma_eval_req     = pma_eval_req_q;
  assign pma_eval_g67     = pma_eval_g67_q;
  assign phy_status       = (state_q == STATUS);
  assign eval_busy        = (state_q != IDLE);
  assign eval_timeout_err = eval_timeout_err_q;

endmodule

// File: tb/tb_cdnsdru_usb4_message_bus_link_eval_req_regs_v4.sv
// tb/tb_cdnsdru_usb4_message_bus_link_eval_req_regs_v4.sv - self-checking bench for the link-eval request FSM
module tb_cdnsdru_usb4_message_bus_link_eval_req_regs_v4;
  localparam logic [15:0] TMO = 16'd4096;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cdb_reset = 1'b0;
  logic       cdb_ctrl_reset = 1'b0;
  logic       done = 1'b0;
  logic [3:0] rate = 4'd0;
  logic rx_eq_eval, rx_eq_eval_sel, pma_eval_req, pma_eval_g67;
  logic phy_status, eval_busy, eval_timeout_err;

  int checks = 0;
  int failures = 0;

  cdnsdru_usb4_message_bus_link_eval_req_regs_v4_if mb_if ();

  cdnsdru_usb4_message_bus_link_eval_req_regs_v4 #(
    .ADDR_RX_CTRL3(12'h003),
    .TIMEOUT_CYC  (TMO)
  ) dut (
    .pipe_mac2phy_clk      (clk),
    .pipe_mac2phy_rstn     (rstn),
    .cdb_reset             (cdb_reset),
    .cdb_ctrl_reset        (cdb_ctrl_reset),
    .mb                    (mb_if.slave),
    .pma_eval_done         (done),
    .pipe_rate_mac2phy_sync(rate),
    .rx_eq_eval            (rx_eq_eval),
    .rx_eq_eval_sel        (rx_eq_eval_sel),
    .pma_eval_req          (pma_eval_req),
    .pma_eval_g67          (pma_eval_g67),
    .phy_status            (phy_status),
    .eval_busy             (eval_busy),
    .eval_timeout_err      (eval_timeout_err)
  );

  always #5 clk = ~clk;

  // Expected bit order: {rx_eq_eval, sel, req, g67, phy_status, busy, timeout_err}
  typedef struct {
    logic        wv;
    logic [11:0] addr;
    logic [7:0]  data;
    logic        dn;
    logic [3:0]  rt;
    logic        cr;
    logic        ccr;
    int          rep;
    logic [6:0]  exp;
    string       name;
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] exp_q[$];

  function automatic vec_t mk(logic wv, logic [11:0] a, logic [7:0] d, logic dn, logic [3:0] rt,
                              logic cr, logic ccr, int rep, logic [6:0] exp, string nm);
    vec_t v;
    v.wv = wv; v.addr = a; v.data = d; v.dn = dn; v.rt = rt;
    v.cr = cr; v.ccr = ccr; v.rep = rep; v.exp = exp; v.name = nm;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {rx_eq_eval, rx_eq_eval_sel, pma_eval_req, pma_eval_g67, phy_status, eval_busy, eval_timeout_err};
  endfunction

  task automatic check(input string nm, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", nm, got, exp);
    end
  endtask

  task automatic apply(input logic wv, input logic [11:0] a, input logic [7:0] d, input logic dn,
                       input logic [3:0] rt, input logic cr, input logic ccr,
                       input logic [6:0] exp, input string nm);
    logic [6:0] e;
    @(negedge clk);
    mb_if.mb_rx_wr_valid = wv;
    mb_if.mb_rx_wr_addr  = a;
    mb_if.mb_rx_wr_data  = d;
    done = dn; rate = rt; cdb_reset = cr; cdb_ctrl_reset = ccr;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(nm, outs(), e);
  endtask

  task automatic idle(input logic [3:0] rt, input logic [6:0] exp, input string nm);
    apply(1'b0, 12'h000, 8'h00, 1'b0, rt, 1'b0, 1'b0, exp, nm);
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d, input logic [3:0] rt,
                    input logic dn, input logic [6:0] exp, input string nm);
    apply(1'b1, a, d, dn, rt, 1'b0, 1'b0, exp, nm);
  endtask

  initial begin
    mb_if.mb_rx_wr_valid = 1'b0;
    mb_if.mb_rx_wr_addr  = 12'h000;
    mb_if.mb_rx_wr_data  = 8'h00;

    vecs.push_back(mk(0, 12'h000, 8'h00, 0, 4'h5, 0, 0, 2,  7'b0000000, "idle_after_reset"));
    vecs.push_back(mk(1, 12'h003, 8'h01, 0, 4'h5, 0, 0, 1,  7'b1011010, "start_g67"));
    vecs.push_back(mk(0, 12'h000, 8'h00, 0, 4'h5, 0, 0, 19, 7'b1011010, "wait_pma"));
    vecs.push_back(mk(0, 12'h000, 8'h00, 1, 4'h5, 0, 0, 1,  7'b1001110, "done_to_status"));
    vecs.push_back(mk(0, 12'h000, 8'h00, 0, 4'h5, 0, 0, 1,  7'b1001010, "hold"));
    vecs.push_back(mk(0, 12'h000, 8'h00, 1, 4'h5, 0, 0, 1,  7'b1001010, "done_in_hold_ignored"));
    vecs.push_back(mk(1, 12'h003, 8'h03, 0, 4'h5, 0, 0, 1,  7'b1001010, "start_in_hold_ignored"));
    vecs.push_back(mk(1, 12'h003, 8'h00, 0, 4'h5, 0, 0, 1,  7'b0001000, "hold_exit"));
    vecs.push_back(mk(1, 12'h003, 8'h01, 0, 4'h3, 0, 0, 1,  7'b1010010, "start_g0"));
    vecs.push_back(mk(0, 12'h000, 8'h00, 0, 4'h3, 0, 0, 3,  7'b1010010, "wait_g0"));
    vecs.push_back(mk(1, 12'h003, 8'h00, 1, 4'h3, 0, 0, 1,  7'b0000000, "abort_with_done"));
    vecs.push_back(mk(0, 12'h000, 8'h00, 0, 4'h3, 0, 0, 2,  7'b0000000, "no_status_after_abort"));
    vecs.push_back(mk(1, 12'h003, 8'h01, 0, 4'h3, 0, 0, 1,  7'b1010010, "start_sel0"));
    vecs.push_back(mk(1, 12'h003, 8'h03, 0, 4'h3, 0, 0, 1,  7'b1010010, "restart_ignored"));
    vecs.push_back(mk(1, 12'h004, 8'h01, 0, 4'h3, 0, 0, 1,  7'b1010010, "other_addr_start"));
    vecs.push_back(mk(1, 12'h004, 8'h00, 0, 4'h3, 0, 0, 1,  7'b1010010, "other_addr_stop"));
    vecs.push_back(mk(0, 12'h000, 8'h00, 0, 4'h5, 0, 0, 2,  7'b1010010, "rate_change_no_g67"));
    vecs.push_back(mk(1, 12'h003, 8'h00, 0, 4'h5, 0, 0, 1,  7'b0000000, "abort_wait"));
    vecs.push_back(mk(1, 12'h003, 8'h01, 0, 4'h5, 0, 0, 1,  7'b1011010, "start_for_ctrl_rst"));
    vecs.push_back(mk(0, 12'h000, 8'h00, 1, 4'h5, 0, 1, 1,  7'b0000000, "cdb_ctrl_reset_wins"));
    vecs.push_back(mk(0, 12'h000, 8'h00, 0, 4'h5, 0, 0, 2,  7'b0000000, "idle_after_ctrl_rst"));
    vecs.push_back(mk(1, 12'h003, 8'h03, 0, 4'h5, 0, 0, 1,  7'b1111010, "start_sel1_g67"));
    vecs.push_back(mk(1, 12'h003, 8'h01, 0, 4'h5, 1, 0, 1,  7'b0000000, "cdb_reset_wins"));

    repeat (2) begin
      #3;
      check("reset_low", outs(), 7'b0000000);
      @(posedge clk);
    end
    @(negedge clk);
    rstn = 1'b1;

    foreach (vecs[i])
      for (int r = 0; r < vecs[i].rep; r++)
        apply(vecs[i].wv, vecs[i].addr, vecs[i].data, vecs[i].dn, vecs[i].rt,
              vecs[i].cr, vecs[i].ccr, vecs[i].exp, vecs[i].name);

    // Timeout: status lands TIMEOUT_CYC cycles after WAIT_PMA is entered.
    wr(12'h003, 8'h03, 4'h3, 1'b0, 7'b1110010, "tmo_start");
    for (int i = 0; i < int'(TMO) - 1; i++) idle(4'h3, 7'b1110010, "tmo_wait");
    idle(4'h3, 7'b1100111, "tmo_status");
    idle(4'h3, 7'b1100011, "tmo_hold_sticky");

    // Asynchronous reset while in HOLD.
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rstn_async_hold", outs(), 7'b0000000);
    @(posedge clk);
    #1;
    check("rstn_held", outs(), 7'b0000000);
    @(negedge clk);
    rstn = 1'b1;
    idle(4'h3, 7'b0000000, "after_rstn");

    // Abort coinciding with the timeout cycle suppresses status and the error.
    wr(12'h003, 8'h01, 4'h3, 1'b0, 7'b1010010, "tmo2_start");
    for (int i = 0; i < int'(TMO) - 1; i++) idle(4'h3, 7'b1010010, "tmo2_wait");
    wr(12'h003, 8'h00, 4'h3, 1'b0, 7'b0000000, "abort_at_timeout");
    idle(4'h3, 7'b0000000, "no_status_after_tmo_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
